// File: rtl/button_pulse_emitter.sv
`default_nettype none
// ============================================================================
// Module   : button_pulse_emitter
// Purpose  : Accepts a 4-bit word on a valid/ready handshake and replays it
//            as one start pulse followed by four MSB-first bit pulses
//            (button1 for a 1 bit, button0 for a 0 bit). Each pulse is
//            PULSE_CYC cycles high and is followed by GAP_CYC low cycles.
//            All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module button_pulse_emitter #(
  parameter int unsigned PULSE_CYC = 4,  // 1..255
  parameter int unsigned GAP_CYC   = 4   // 2..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic       start,
  output logic       button0,
  output logic       button1,
  output logic       busy,
  output logic       done
);

  // Terminal counts for the 8-bit phase counter.
  localparam logic [7:0] c_pulse_last = 8'(PULSE_CYC - 1);
  localparam logic [7:0] c_gap_last   = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START_HI = 3'd1,
    S_START_LO = 3'd2,
    S_BIT_HI   = 3'd3,
    S_BIT_LO   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] shreg_q, shreg_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [1:0] idx_q,   idx_d;
  logic       start_q, start_d;
  logic       b0_q,    b0_d;
  logic       b1_q,    b1_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       ready_q, ready_d;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    b0_d    = 1'b0;
    b1_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ready_q is low on the first cycle after reset, so no accept then.
        if (in_valid && ready_q) begin
          shreg_d = in_data;
          cnt_d   = 8'd0;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_START_HI;
        end else begin
          ready_d = 1'b1;
        end
      end

      S_START_HI: begin
        busy_d = 1'b1;
        if (cnt_q == c_pulse_last) begin
          cnt_d   = 8'd0;
          state_d = S_START_LO;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          start_d = 1'b1;
        end
      end

      S_START_LO: begin
        busy_d = 1'b1;
        if (cnt_q == c_gap_last) begin
          cnt_d   = 8'd0;
          idx_d   = 2'd0;
          b1_d    = shreg_q[3];
          b0_d    = ~shreg_q[3];
          state_d = S_BIT_HI;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_BIT_HI: begin
        busy_d = 1'b1;
        if (cnt_q == c_pulse_last) begin
          cnt_d   = 8'd0;
          shreg_d = {shreg_q[2:0], 1'b0};
          state_d = S_BIT_LO;
        end else begin
          cnt_d = cnt_q + 8'd1;
          b1_d  = shreg_q[3];
          b0_d  = ~shreg_q[3];
        end
      end

      S_BIT_LO: begin
        busy_d = 1'b1;
        if (cnt_q == c_gap_last) begin
          cnt_d = 8'd0;
          if (idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // Register already shifted on leaving BIT_HI, so [3] is the next bit.
            idx_d   = idx_q + 2'd1;
            b1_d    = shreg_q[3];
            b0_d    = ~shreg_q[3];
            state_d = S_BIT_HI;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides everything outside IDLE, including the DONE strobe.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      start_d = 1'b0;
      b0_d    = 1'b0;
      b1_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ready_d = 1'b1;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= 4'd0;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      start_q <= 1'b0;
      b0_q    <= 1'b0;
      b1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign start    = start_q;
  assign button0  = b0_q;
  assign button1  = b1_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_emitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_pulse_emitter
// Purpose  : Self-checking bench for button_pulse_emitter. Two instances
//            (4/4 and 1/2 timing) share stimulus; each is compared every
//            cycle against a timeline model, and a small receiver
//            reassembles words from the 4/4 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_pulse_emitter;

  localparam int c_pa = 4, c_ga = 4;
  localparam int c_pb = 1, c_gb = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;

  logic a_ready, a_start, a_b0, a_b1, a_busy, a_done;
  logic b_ready, b_start, b_b0, b_b1, b_busy, b_done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_pulse_emitter #(.PULSE_CYC(c_pa), .GAP_CYC(c_ga)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .abort(abort), .start(a_start), .button0(a_b0),
    .button1(a_b1), .busy(a_busy), .done(a_done)
  );

  button_pulse_emitter #(.PULSE_CYC(c_pb), .GAP_CYC(c_gb)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_ready), .abort(abort), .start(b_start), .button0(b_b0),
    .button1(b_b1), .busy(b_busy), .done(b_done)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: mode 0 = in reset (or first cycle after), 1 = idle, 2 = sending
  // with k = cycles since the accept edge.
  task automatic model_step(input int mode_i, input int k_i, input logic [3:0] w_i,
                            input int p, input int g,
                            output int mode_o, output int k_o, output logic [3:0] w_o);
    int n;
    n      = 5 * (p + g);
    mode_o = mode_i;
    k_o    = k_i;
    w_o    = w_i;
    if (rst) begin
      mode_o = 0;
    end else if (mode_i == 2) begin
      if (abort || k_i == n) mode_o = 1;
      else k_o = k_i + 1;
    end else if (mode_i == 1 && in_valid) begin
      mode_o = 2;
      k_o    = 0;
      w_o    = in_data;
    end else begin
      mode_o = 1;
    end
  endtask

  // Expected {in_ready, busy, done, start, button1, button0}.
  function automatic logic [7:0] model_out(input int mode, input int k, input logic [3:0] w,
                                           input int p, input int g);
    logic [7:0] r;
    logic [3:0] wv;
    int ph, wi;
    r  = 8'd0;
    wv = w;
    if (mode == 1) begin
      r[5] = 1'b1;
    end else if (mode == 2) begin
      r[4] = 1'b1;
      if (k == 5 * (p + g)) begin
        r[3] = 1'b1;
      end else begin
        ph = k / (p + g);
        wi = k % (p + g);
        if (wi < p) begin
          if (ph == 0) r[2] = 1'b1;
          else if (wv[4 - ph]) r[1] = 1'b1;
          else r[0] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  int         mode_a = 0, k_a = 0, mode_b = 0, k_b = 0;
  logic [3:0] w_a = 4'd0, w_b = 4'd0;

  // Advance both models on each rising edge with the inputs the DUTs see.
  always @(posedge clk) begin
    int m, k;
    logic [3:0] w;
    model_step(mode_a, k_a, w_a, c_pa, c_ga, m, k, w);
    mode_a = m; k_a = k; w_a = w;
    model_step(mode_b, k_b, w_b, c_pb, c_gb, m, k, w);
    mode_b = m; k_b = k; w_b = w;
    if (rst) chk_en = 1'b1;
  end

  // Loopback receiver state: bits latched on the falling edge of a button pulse.
  logic [3:0] rx_word = 4'd0;
  logic       pb0 = 1'b0, pb1 = 1'b0;

  // Compare both DUTs against the model away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("outs_a", {2'b00, a_ready, a_busy, a_done, a_start, a_b1, a_b0},
                model_out(mode_a, k_a, w_a, c_pa, c_ga));
      check_val("outs_b", {2'b00, b_ready, b_busy, b_done, b_start, b_b1, b_b0},
                model_out(mode_b, k_b, w_b, c_pb, c_gb));
      check_val("excl_a", 8'(a_start + a_b0 + a_b1) <= 8'd1 ? 8'd1 : 8'd0, 8'd1);
      check_val("excl_b", 8'(b_start + b_b0 + b_b1) <= 8'd1 ? 8'd1 : 8'd0, 8'd1);
      if (a_start) rx_word = 4'd0;
      if (pb1 && !a_b1) rx_word = {rx_word[2:0], 1'b1};
      if (pb0 && !a_b0) rx_word = {rx_word[2:0], 1'b0};
      if (a_done) check_val("rx_word", {4'd0, rx_word}, {4'd0, w_a});
      pb0 = a_b0;
      pb1 = a_b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic wait_ready_a();
    int i;
    i = 0;
    while (!a_ready && i < 200) begin
      tick();
      i++;
    end
    if (i >= 200) check_val("ready_timeout", {7'd0, a_ready}, 8'd1);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Basic word with fixed timing.
    send(4'b1011);
    repeat (45) tick();

    // Back-to-back all-zeros then all-ones.
    wait_ready_a();
    send(4'b0000);
    repeat (5) tick();
    wait_ready_a();
    send(4'b1111);
    repeat (5) tick();

    // Every word through the loopback receiver.
    for (int w = 0; w < 16; w++) begin
      wait_ready_a();
      send(4'(w));
      repeat (3) tick();
    end

    // Abort during the second bit pulse, then a normal word.
    wait_ready_a();
    send(4'b1010);
    repeat (17) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_ready_a();
    send(4'b0110);
    repeat (45) tick();

    // Reset in the middle of a transfer, then a fresh word.
    wait_ready_a();
    send(4'b1100);
    repeat (9) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send(4'b1011);
    repeat (45) tick();

    // Randomized traffic including occasional abort and reset.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 4'($urandom);
      abort    = ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 511) == 0);
      tick();
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
    repeat (50) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
